// File: rtl/uart_mem_dumper.sv
// Memory-to-UART readback: streams a byte range from a synchronous-read
// memory port out of UART_TXD as 8N1 frames, LSB first.
module uart_mem_dumper #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int ADDR_W       = 10
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic [ADDR_W-1:0] BASE_ADDR,
   input  logic [ADDR_W:0]   LENGTH,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [7:0]        MEM_RDATA,
   output logic              UART_TXD,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W:0]   SENT
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START_BIT,
      S_DATA_BITS,
      S_STOP_BIT,
      S_FINISH
   } state_t;

   state_t            r_state, w_state_n;
   logic [CW-1:0]     r_cnt, w_cnt_n;
   logic [2:0]        r_bit, w_bit_n;
   logic [7:0]        r_shift, w_shift_n;
   logic [ADDR_W-1:0] r_addr, w_addr_n;
   logic [ADDR_W:0]   r_rem, w_rem_n;
   logic [ADDR_W:0]   r_sent, w_sent_n;
   logic              r_txd, w_txd_n;
   logic              w_tick;

   assign w_tick   = (r_cnt == LAST);
   assign MEM_ADDR = r_addr;
   assign UART_TXD = r_txd;
   assign SENT     = r_sent;
   assign BUSY     = (r_state != S_IDLE);
   assign DONE     = (r_state == S_FINISH);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_addr  <= '0;
         r_rem   <= '0;
         r_sent  <= '0;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_shift <= w_shift_n;
         r_addr  <= w_addr_n;
         r_rem   <= w_rem_n;
         r_sent  <= w_sent_n;
         r_txd   <= w_txd_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_bit_n   = r_bit;
      w_shift_n = r_shift;
      w_addr_n  = r_addr;
      w_rem_n   = r_rem;
      w_sent_n  = r_sent;
      w_txd_n   = r_txd;
      unique case (r_state)
         S_IDLE: begin
            w_txd_n = 1'b1;
            if (START) begin
               w_sent_n = '0;
               if (LENGTH != '0) begin
                  w_addr_n  = BASE_ADDR;
                  w_rem_n   = LENGTH;
                  w_state_n = S_FETCH;
               end else begin
                  w_state_n = S_FINISH;
               end
            end
         end
         S_FETCH: w_state_n = S_LOAD;
         S_LOAD: begin
            w_shift_n = MEM_RDATA;
            w_txd_n   = 1'b0;
            w_cnt_n   = '0;
            w_state_n = S_START_BIT;
         end
         S_START_BIT: begin
            if (w_tick) begin
               w_cnt_n   = '0;
               w_bit_n   = '0;
               w_txd_n   = r_shift[0];
               w_state_n = S_DATA_BITS;
            end else begin
               w_cnt_n = r_cnt + CW'(1);
            end
         end
         S_DATA_BITS: begin
            if (w_tick) begin
               w_cnt_n = '0;
               if (r_bit == 3'd7) begin
                  w_txd_n   = 1'b1;
                  w_state_n = S_STOP_BIT;
               end else begin
                  // next bit comes from the pre-shift register's bit 1
                  w_shift_n = {1'b0, r_shift[7:1]};
                  w_txd_n   = r_shift[1];
                  w_bit_n   = r_bit + 3'd1;
               end
            end else begin
               w_cnt_n = r_cnt + CW'(1);
            end
         end
         S_STOP_BIT: begin
            if (w_tick) begin
               w_cnt_n  = '0;
               w_sent_n = r_sent + (ADDR_W+1)'(1);
               w_rem_n  = r_rem - (ADDR_W+1)'(1);
               if (r_rem == (ADDR_W+1)'(1)) begin
                  w_state_n = S_FINISH;
               end else begin
                  w_addr_n  = r_addr + ADDR_W'(1);
                  w_state_n = S_FETCH;
               end
            end else begin
               w_cnt_n = r_cnt + CW'(1);
            end
         end
         S_FINISH: w_state_n = S_IDLE;
         default:  w_state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Directed bench for uart_mem_dumper: frame decode, timing, wrap,
// zero length, ignored START, mid-frame reset and back-to-back dumps.
module tb_uart_mem_dumper;

   localparam int CPB  = 4;
   localparam int AW   = 10;
   localparam int MAXC = 400;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic          txd;
   logic          busy;
   logic          done;
   logic [AW:0]   sent;

   logic [7:0] mem [1024];

   int n_checks;
   int n_err;

   logic     line_q[$];
   int       addr_q[$];

   typedef struct {
      logic [AW-1:0]   base;
      logic [AW:0]     len;
      bit              noise;
      int              done_cyc;
      logic [3:0][7:0] bytes;
   } vec_t;

   vec_t vecs[5];

   uart_mem_dumper #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .START     (start),
      .BASE_ADDR (base_addr),
      .LENGTH    (length),
      .MEM_ADDR  (mem_addr),
      .MEM_RDATA (mem_rdata),
      .UART_TXD  (txd),
      .BUSY      (busy),
      .DONE      (done),
      .SENT      (sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= mem[mem_addr];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_dump(input logic [AW-1:0] b, input logic [AW:0] l,
                           input bit noise, output int dc,
                           output int snt, output int bsy);
      line_q.delete();
      addr_q.delete();
      dc  = -1;
      snt = -1;
      bsy = -1;
      base_addr = b;
      length    = l;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < MAXC; c++) begin
         line_q.push_back(txd);
         addr_q.push_back(int'(mem_addr));
         if (done) begin
            dc  = c;
            snt = int'(sent);
            bsy = int'(busy);
            break;
         end
         if (noise && (c % 37 == 10)) begin
            start     = 1'b1;
            base_addr = 10'd0;
            length    = 11'd2;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic check_vec(input int vi);
      vec_t v;
      int   dc, snt, bsy, nfr, prev, i;
      logic [7:0] by;
      v = vecs[vi];
      run_dump(v.base, v.len, v.noise, dc, snt, bsy);
      chk($sformatf("v%0d done_cycle", vi), dc, v.done_cyc);
      chk($sformatf("v%0d sent", vi), snt, int'(v.len));
      chk($sformatf("v%0d busy_at_done", vi), bsy, 1);
      nfr  = 0;
      prev = -1;
      i    = 0;
      while (i < line_q.size()) begin
         if (line_q[i] == 1'b0) begin
            if (i + 39 >= line_q.size()) begin
               chk($sformatf("v%0d frame_truncated", vi), i, -1);
               break;
            end
            by = '0;
            for (int k = 0; k < 8; k++) by[k] = line_q[i + CPB*(k+1) + 2];
            if (nfr == 0)
               chk($sformatf("v%0d first_start", vi), i, 2);
            else
               chk($sformatf("v%0d frame_spacing", vi), i - prev, 42);
            if (nfr < 4) begin
               chk($sformatf("v%0d byte%0d", vi, nfr), int'(by),
                   int'(v.bytes[nfr]));
               chk($sformatf("v%0d addr%0d", vi, nfr), addr_q[i],
                   (int'(v.base) + nfr) % 1024);
            end
            chk($sformatf("v%0d stop%0d", vi, nfr),
                int'(line_q[i + 38]), 1);
            prev = i;
            nfr++;
            i += 40;
         end else begin
            i++;
         end
      end
      chk($sformatf("v%0d frames", vi), nfr, int'(v.len));
      @(negedge clk);
      chk($sformatf("v%0d done_low_after", vi), int'(done), 0);
      chk($sformatf("v%0d busy_low_after", vi), int'(busy), 0);
      chk($sformatf("v%0d txd_idle_after", vi), int'(txd), 1);
   endtask

   initial begin
      int dc, snt, bsy, seen_done, seen_low;
      n_checks  = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      for (int a = 0; a < 1024; a++) mem[a] = 8'hC3;
      mem[5]    = 8'hA5;
      mem[1022] = 8'h11;
      mem[1023] = 8'h22;
      mem[0]    = 8'h33;
      mem[1]    = 8'h44;
      mem[100]  = 8'hDE;
      mem[101]  = 8'hAD;
      mem[102]  = 8'hBE;

      vecs[0] = '{10'd5,    11'd1, 1'b0, 42,  {8'h00, 8'h00, 8'h00, 8'hA5}};
      vecs[1] = '{10'd1022, 11'd4, 1'b0, 168, {8'h44, 8'h33, 8'h22, 8'h11}};
      vecs[2] = '{10'd100,  11'd3, 1'b0, 126, {8'h00, 8'hBE, 8'hAD, 8'hDE}};
      vecs[3] = '{10'd7,    11'd0, 1'b0, 0,   {8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[4] = '{10'd100,  11'd3, 1'b1, 126, {8'h00, 8'hBE, 8'hAD, 8'hDE}};

      repeat (3) @(negedge clk);
      chk("reset_txd", int'(txd), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_mem_addr", int'(mem_addr), 0);
      chk("reset_sent", int'(sent), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++) check_vec(v);

      base_addr = 10'd100;
      length    = 11'd3;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (59) @(negedge clk);
      chk("pre_reset_busy", int'(busy), 1);
      chk("pre_reset_sent", int'(sent), 1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_txd", int'(txd), 1);
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_done", int'(done), 0);
      chk("async_reset_sent", int'(sent), 0);
      chk("async_reset_addr", int'(mem_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      seen_low  = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done) seen_done++;
         if (!txd) seen_low++;
      end
      chk("post_reset_no_done", seen_done, 0);
      chk("post_reset_txd_high", seen_low, 0);

      check_vec(2);

      run_dump(10'd7, 11'd0, 1'b0, dc, snt, bsy);
      chk("len0_done_cycle", dc, 0);
      seen_low = 0;
      for (int c = 0; c < line_q.size(); c++) if (!line_q[c]) seen_low++;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!txd) seen_low++;
      end
      chk("len0_txd_high", seen_low, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
